// File: rtl/mult_pkg.sv
// Shared encodings and helpers for the iterative shift-add multiplier.
package mult_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_FIX  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_FIX  = ST_FIX,
        S_DONE = ST_DONE
    } state_e;

    // Ceiling log2; used to size the iteration counter as clog2(WIDTH+1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement negate: mag_c = neg ? -x : x (modulo 2^W).
module mult_abs #(
    parameter int unsigned W = 8
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] mag_c
);

    // Negation wraps, so |-2^(W-1)| comes out as 2^(W-1) read unsigned.
    always_comb begin
        mag_c = x;
        if (neg) begin
            mag_c = (~x) + W'(1);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, signed or unsigned per operation, with
// start/done handshake and WIDTH-bit-fit overflow flag.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = clog2(WIDTH + 1);

    state_e             state_q;
    state_e             state_d;
    logic               busy_d;
    logic               done_d;
    logic               load_c;
    logic               step_c;
    logic               fix_c;

    logic [CNT_W-1:0]   cnt_q;
    logic [PW-1:0]      acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               neg_q;
    logic               mode_q;

    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [PW-1:0]      res_c;
    logic [WIDTH:0]     sum_c;
    logic [PW-1:0]      acc_step_c;
    logic               ovf_c;

    assign a_neg_c = is_signed & a[WIDTH-1];
    assign b_neg_c = is_signed & b[WIDTH-1];

    mult_abs #(.W(WIDTH)) u_abs_a (
        .neg   (a_neg_c),
        .x     (a),
        .mag_c (a_mag_c)
    );

    mult_abs #(.W(WIDTH)) u_abs_b (
        .neg   (b_neg_c),
        .x     (b),
        .mag_c (b_mag_c)
    );

    mult_abs #(.W(PW)) u_abs_res (
        .neg   (neg_q),
        .x     (acc_q),
        .mag_c (res_c)
    );

    // One shift-add step: add multiplicand into the upper half, then shift right.
    always_comb begin
        sum_c = {1'b0, acc_q[PW-1:WIDTH]};
        if (mplier_q[0]) begin
            sum_c = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q};
        end
        acc_step_c = {sum_c, acc_q[WIDTH-1:1]};
    end

    // Fit check on the final value: unsigned needs a zero upper half, signed
    // needs the upper half plus the WIDTH-bit sign bit to be uniform.
    always_comb begin
        ovf_c = |res_c[PW-1:WIDTH];
        if (mode_q) begin
            ovf_c = ~((&res_c[PW-1:WIDTH-1]) | ~(|res_c[PW-1:WIDTH-1]));
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        fix_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    load_c  = 1'b1;
                end
            end
            S_RUN: begin
                step_c = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix_c   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            mode_q   <= 1'b0;
            product  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (load_c) begin
                mcand_q  <= a_mag_c;
                mplier_q <= b_mag_c;
                neg_q    <= a_neg_c ^ b_neg_c;
                mode_q   <= is_signed;
                acc_q    <= '0;
                cnt_q    <= CNT_W'(WIDTH);
            end
            if (step_c) begin
                acc_q    <= acc_step_c;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CNT_W'(1);
            end
            if (fix_c) begin
                product <= res_c;
                ovf     <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH = 8.
module tb_seq_multiplier;

    localparam int unsigned WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
        logic        o;
    } vec_t;

    vec_t dir [9] = '{
        '{8'd200, 8'd63,  1'b0, 16'h3138, 1'b1},
        '{8'd15,  8'd10,  1'b0, 16'h0096, 1'b0},
        '{8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1},
        '{8'hF8,  8'hFA,  1'b1, 16'h0030, 1'b0},
        '{8'hF6,  8'h0A,  1'b1, 16'hFF9C, 1'b0},
        '{8'hC0,  8'h96,  1'b1, 16'h1A80, 1'b1},
        '{8'h80,  8'h80,  1'b1, 16'h4000, 1'b1},
        '{8'h80,  8'h01,  1'b1, 16'hFF80, 1'b0},
        '{8'h00,  8'hFF,  1'b1, 16'h0000, 1'b0}
    };

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, then truncate and range-test. Returns {ovf, product}.
    function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        longint px;
        longint py;
        longint p;
        logic   o;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        p  = px * py;
        o  = s ? ((p < -128) || (p > 127)) : (p > 255);
        return {o, 16'(p)};
    endfunction

    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic s,
                          input logic [15:0] ep, input logic eo, input string tag);
        int lat;
        @(negedge clk);
        a = aa; b = bb; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
        check({tag, "_busy_t0"}, 64'(busy), 64'(1));
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(9));
        check({tag, "_product"}, 64'(product), 64'(ep));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        check({tag, "_busy_done"}, 64'(busy), 64'(1));
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 64'(done), 64'(0));
        check({tag, "_busy_end"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [16:0] m;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        s;
        int          n;
        int          last;
        int          lat;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (dir[i]) begin
            run_op(dir[i].a, dir[i].b, dir[i].s, dir[i].p, dir[i].o, $sformatf("dir%0d", i));
        end

        // Random vectors against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'($urandom);
            m = model(x, y, s);
            run_op(x, y, s, m[15:0], m[16], $sformatf("rnd%0d", i));
        end

        // Start held through RUN and DONE with different operands is dropped
        @(negedge clk);
        a = 8'h11; b = 8'h22; is_signed = 1'b0; start = 1'b1;
        m = model(8'h11, 8'h22, 1'b0);
        @(posedge clk); #1;
        a = 8'h33; b = 8'h44;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("drop_latency", 64'(lat), 64'(9));
        check("drop_product", 64'(product), 64'(m[15:0]));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("drop_no_extra_done", 64'(n), 64'(0));
        check("drop_idle", 64'(busy), 64'(0));
        check("drop_product_held", 64'(product), 64'(m[15:0]));

        // Asynchronous reset in the fourth RUN cycle
        @(negedge clk);
        a = 8'h9D; b = 8'h77; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_ovf", 64'(ovf), 64'(0));
        check("mid_rst_product", 64'(product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd3, 8'd5, 1'b0, 16'h000F, 1'b0, "post_rst");

        // Start held continuously: done every WIDTH+3 cycles, product stable
        x = 8'($urandom);
        y = 8'($urandom);
        s = 1'($urandom);
        m = model(x, y, s);
        @(negedge clk);
        a = x; b = y; is_signed = s; start = 1'b1;
        last = -1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (last >= 0) check("b2b_gap", 64'(c - last), 64'(11));
                last = c;
                n++;
            end
            if (n > 0) check("b2b_product_stable", 64'(product), 64'(m[15:0]));
        end
        check("b2b_pulses", 64'(n), 64'(3));
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (busy && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_drain", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised, iterative shift-add multiplier for WIDTH-bit operands, selectable signed or unsigned per operation, with a start/done handshake and overflow detection. It replaces the fully combinational 8-bit unsigned and signed array multipliers in the ALU datapath. It trades area for latency: one partial product is accumulated per clock, and the full 2*WIDTH-bit product and a WIDTH-bit-fit overflow flag are delivered together.

## Interface
- WIDTH, 8: operand width in bits; legal range is WIDTH >= 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in state IDLE; ignored in all other states.
- is_signed  in  1  operation mode: 1 = two's-complement operands, 0 = unsigned. Captured with start.
- a  in  WIDTH  multiplicand, captured with start.
- b  in  WIDTH  multiplier, captured with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse indicating that product and ovf are valid.
- product  out  2*WIDTH  full product, in two's complement when is_signed = 1. Held until the next accepted start.
- ovf  out  1  the product does not fit in WIDTH bits under the captured mode. Held with product.

## Operation
- States are IDLE, RUN, FIX and DONE.
- IDLE:
  - On start = 1, capture is_signed and register the operand magnitudes: |a| and |b| when signed, raw a and b when unsigned.
  - Capture neg = is_signed & (a[W-1] ^ b[W-1]).
  - Clear the accumulator, load cnt = WIDTH, and go to RUN.
- RUN:
  - Each cycle, if the multiplier LSB = 1, add the multiplicand to the accumulator.
  - Shift the accumulator and multiplier right by one, and decrement cnt.
  - When cnt = 1 on an edge, go to FIX.
- FIX:
  - Set product = neg ? -acc : acc, computed modulo 2^(2W).
  - Compute ovf from that final value and go to DONE.
- DONE: assert done for exactly one cycle, then go to IDLE.
- Magnitude arithmetic:
  - A magnitude fits in WIDTH bits unsigned, including |-2^(W-1)| = 2^(W-1).
  - The accumulator is 2*WIDTH bits wide and never overflows.
- Overflow rules:
  - Unsigned: ovf = OR of product[2W-1:W].
  - Signed: ovf = 1 unless product[2W-1:W-1] are all equal.
- A start asserted while busy = 1 (including during DONE) is dropped. It is not queued.
- Reset (asynchronous, at any time including mid-operation):
  - state = IDLE; busy, done and ovf = 0; product = 0; cnt and accumulator cleared.
  - Operation resumes normally on the first start after rst_n deasserts.

## Timing
- Start is accepted at edge t0.
- busy is high from t0 through edge t0+WIDTH+2.
- product and ovf update at edge t0+WIDTH+1.
- done is high for the single cycle between edges t0+WIDTH+1 and t0+WIDTH+2.
- Worked example, WIDTH = 8: done is observed 9 edges after the start edge.
- Throughput: the earliest next accept is edge t0+WIDTH+3, one accept every WIDTH+3 cycles. This requires start held high or re-asserted in IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.
- a, b and is_signed may change freely after the start edge.

## Structure
- mult_pkg holds:
  - state encoding localparams: ST_IDLE, ST_RUN, ST_FIX, ST_DONE.
  - the state-register width.
  - the counter-width function clog2(WIDTH+1).
- One sub-module, mult_abs (parametrised width, combinational conditional two's-complement negate), instantiated for:
  - operand a at WIDTH bits;
  - operand b at WIDTH bits;
  - the final result at 2*WIDTH bits.
- The FSM, counter and accumulator stay in seq_multiplier.

## Test plan
All scenarios use WIDTH = 8.
- Unsigned: 200×63 → product 0x3138, ovf=1. 15×10 → 0x0096, ovf=0. 255×255 → 0xFE01, ovf=1. done is high for exactly one cycle, at edge t0+9.
- Signed: -8×-6 → 0x0030, ovf=0. -10×10 → 0xFF9C, ovf=0. -64×-106 (a=0xC0, b=0x96) → 0x1A80, ovf=1.
- Signed corner cases: -128×-128 → 0x4000, ovf=1. -128×1 → 0xFF80, ovf=0. 0×-1 → 0x0000, ovf=0.
- Dropped start: with start held high during RUN and with different operands, the first result is unchanged. The second operation begins only after IDLE is reached, with no extra done pulse.
- Reset mid-operation: drop rst_n at cycle 4 of RUN → busy, done and ovf = 0 and product = 0 immediately, before the next clock. Then 3×5 → 0x000F after the full latency.
- Back-to-back: with start held continuously, consecutive done pulses are exactly 11 cycles apart. product is stable between its updates.
